// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioning: synchronize, debounce, validate the mode selector,
// and produce a start pulse / stop level for the run controller.

module panel_input_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The counter only runs while the input disagrees, so it clears before it could wrap.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_s != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                deb_d = sync_s;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module panel_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_raw,
    input  logic stop_raw,
    input  logic auto_sw,
    input  logic man_sw,
    input  logic estop_n_raw,
    output logic start,
    output logic stop,
    output logic AUTO,
    output logic MAN,
    output logic fault
);
    typedef enum logic [1:0] {IDLE, AUTO_M, MAN_M, FAULT} state_t;

    logic [3:0]             raw_vec, deb_vec;
    logic [SYNC_STAGES-1:0] estop_sync_q;
    logic                   ds, dstop, da, dm, estop_act;
    logic                   ds_prev_q, start_q, start_d;
    state_t                 state_q, state_d;

    assign raw_vec = {man_sw, auto_sw, stop_raw, start_raw};

    for (genvar i = 0; i < 4; i++) begin : g_db
        panel_input_conditioner_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw_i(raw_vec[i]),
            .deb_o(deb_vec[i])
        );
    end

    assign ds    = deb_vec[0];
    assign dstop = deb_vec[1];
    assign da    = deb_vec[2];
    assign dm    = deb_vec[3];

    // E-stop is never debounced; its synchronizer resets to the asserted (0) level.
    assign estop_act = ~estop_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        if (estop_act) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE:    if (da && dm) state_d = FAULT;
                         else if (da)  state_d = AUTO_M;
                         else if (dm)  state_d = MAN_M;
                AUTO_M:  if (dm)       state_d = FAULT;
                         else if (!da) state_d = IDLE;
                MAN_M:   if (da)       state_d = FAULT;
                         else if (!dm) state_d = IDLE;
                default: if (!da && !dm) state_d = IDLE;
            endcase
        end
    end

    assign stop    = dstop | estop_act | (state_q == FAULT);
    assign start_d = ds & ~ds_prev_q & ((state_q == AUTO_M) | (state_q == MAN_M)) & ~stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estop_sync_q <= '0;
            state_q      <= FAULT;
            ds_prev_q    <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            estop_sync_q <= {estop_sync_q[SYNC_STAGES-2:0], estop_n_raw};
            state_q      <= state_d;
            ds_prev_q    <= ds;
            start_q      <= start_d;
        end
    end

    assign start = start_q;
    assign AUTO  = (state_q == AUTO_M);
    assign MAN   = (state_q == MAN_M);
    assign fault = (state_q == FAULT);
endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.

module tb_panel_input_conditioner;
    logic clk, rst;
    logic start_raw, stop_raw, auto_sw, man_sw, estop_n_raw;
    logic start, stop, AUTO, MAN, fault;
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;

    panel_input_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .start_raw(start_raw), .stop_raw(stop_raw), .auto_sw(auto_sw),
        .man_sw(man_sw), .estop_n_raw(estop_n_raw),
        .start(start), .stop(stop), .AUTO(AUTO), .MAN(MAN), .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (start === 1'b1) pulse_cnt++;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_raw = 0; stop_raw = 0; auto_sw = 0; man_sw = 0; estop_n_raw = 1;
        tick(3);
        checks++;
        if ({start, stop, AUTO, MAN, fault} !== 5'b01001) begin
            failures++; $display("FAIL reset_outputs got=%b want=01001", {start, stop, AUTO, MAN, fault});
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (fault !== 1'b1 || stop !== 1'b1) begin
            failures++; $display("FAIL reset_hold2 fault=%b stop=%b want 1 1", fault, stop);
        end
        tick(1);
        checks++;
        if (fault !== 1'b0 || stop !== 1'b0 || AUTO !== 1'b0 || MAN !== 1'b0) begin
            failures++; $display("FAIL reset_idle3 fault=%b stop=%b auto=%b man=%b want 0 0 0 0", fault, stop, AUTO, MAN);
        end
    endtask

    task automatic test_auto_start();
        auto_sw = 1'b1;
        tick(6);
        checks++;
        if (AUTO !== 1'b0) begin failures++; $display("FAIL auto_early got=%b want=0", AUTO); end
        tick(1);
        checks++;
        if (AUTO !== 1'b1 || MAN !== 1'b0) begin
            failures++; $display("FAIL auto_at7 auto=%b man=%b want 1 0", AUTO, MAN);
        end
        pulse_cnt = 0;
        start_raw = 1'b1;
        tick(6);
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL start_early got=%b want=0", start); end
        tick(1);
        checks++;
        if (start !== 1'b1) begin failures++; $display("FAIL start_at7 got=%b want=1", start); end
        tick(1);
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL start_one_cycle got=%b want=0", start); end
        tick(2);
        start_raw = 1'b0;
        tick(10);
        checks++;
        if (pulse_cnt !== 1) begin failures++; $display("FAIL start_single pulses=%0d want=1", pulse_cnt); end
    endtask

    task automatic test_bouncy_start();
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            start_raw = ~start_raw;
            tick(2);
        end
        tick(10);
        checks++;
        if (pulse_cnt !== 0 || AUTO !== 1'b1) begin
            failures++; $display("FAIL bouncy_start pulses=%0d auto=%b want 0 1", pulse_cnt, AUTO);
        end
    endtask

    task automatic test_mode_fault();
        man_sw = 1'b1;
        tick(6);
        checks++;
        if (fault !== 1'b0 || AUTO !== 1'b1) begin
            failures++; $display("FAIL mode_pre fault=%b auto=%b want 0 1", fault, AUTO);
        end
        tick(1);
        checks++;
        if ({fault, AUTO, MAN, stop} !== 4'b1001) begin
            failures++; $display("FAIL mode_fault got=%b want=1001", {fault, AUTO, MAN, stop});
        end
        auto_sw = 1'b0; man_sw = 1'b0;
        tick(6);
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL mode_fault_hold got=%b want=1", fault); end
        tick(1);
        checks++;
        if (fault !== 1'b0 || stop !== 1'b0) begin
            failures++; $display("FAIL mode_recover fault=%b stop=%b want 0 0", fault, stop);
        end
    endtask

    task automatic test_estop_glitch();
        man_sw = 1'b1;
        tick(7);
        checks++;
        if (MAN !== 1'b1 || AUTO !== 1'b0) begin
            failures++; $display("FAIL man_enter man=%b auto=%b want 1 0", MAN, AUTO);
        end
        estop_n_raw = 1'b0;
        tick(1);
        estop_n_raw = 1'b1;
        tick(1);
        checks++;
        if (stop !== 1'b1) begin failures++; $display("FAIL estop_stop got=%b want=1", stop); end
        tick(1);
        checks++;
        if (fault !== 1'b1 || MAN !== 1'b0) begin
            failures++; $display("FAIL estop_fault fault=%b man=%b want 1 0", fault, MAN);
        end
        tick(10);
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL estop_latched got=%b want=1", fault); end
        man_sw = 1'b0;
        tick(7);
        checks++;
        if (fault !== 1'b0 || MAN !== 1'b0) begin
            failures++; $display("FAIL estop_recover fault=%b man=%b want 0 0", fault, MAN);
        end
    endtask

    task automatic test_simul_start_stop();
        man_sw = 1'b1;
        tick(7);
        pulse_cnt = 0;
        start_raw = 1'b1; stop_raw = 1'b1;
        tick(5);
        checks++;
        if (stop !== 1'b0) begin failures++; $display("FAIL simul_stop_early got=%b want=0", stop); end
        tick(1);
        checks++;
        if (stop !== 1'b1) begin failures++; $display("FAIL simul_stop_at6 got=%b want=1", stop); end
        tick(6);
        checks++;
        if (pulse_cnt !== 0 || MAN !== 1'b1) begin
            failures++; $display("FAIL simul_no_start pulses=%0d man=%b want 0 1", pulse_cnt, MAN);
        end
        stop_raw = 1'b0;
        tick(10);
        checks++;
        if (pulse_cnt !== 0 || stop !== 1'b0) begin
            failures++; $display("FAIL held_through_release pulses=%0d stop=%b want 0 0", pulse_cnt, stop);
        end
        start_raw = 1'b0;
        tick(8);
        start_raw = 1'b1;
        tick(7);
        checks++;
        if (start !== 1'b1) begin failures++; $display("FAIL fresh_edge_start got=%b want=1", start); end
        start_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_reset_mid();
        pulse_cnt = 0;
        start_raw = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        checks++;
        if ({start, stop, AUTO, MAN, fault} !== 5'b01001) begin
            failures++; $display("FAIL reset_mid got=%b want=01001", {start, stop, AUTO, MAN, fault});
        end
        tick(3);
        start_raw = 1'b0; man_sw = 1'b0;
        rst = 1'b0;
        tick(12);
        checks++;
        if (pulse_cnt !== 0 || fault !== 1'b0 || MAN !== 1'b0) begin
            failures++; $display("FAIL reset_mid_after pulses=%0d fault=%b man=%b want 0 0 0", pulse_cnt, fault, MAN);
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_bouncy_start();
        test_mode_fault();
        test_estop_glitch();
        test_simul_start_stop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
